if_id_queue: RTL and testbench
==============================

# if_id_queue

Two-entry instruction queue between the IF stage (PC register, next-PC mux, IF PC adder, instruction memory read) and the ID stage. Captures each fetched {PC, PC+4, instruction} triple with a valid/ready handshake, so the decoder can stall without losing a fetched word. Drains its contents on a branch/jump flush. Replaces a bare IF/ID register and drives the PC enable through `IF_Ready`.

## Interface
- `DEPTH`, 2, number of entries; power of two, ≥2.
- `XLEN`, 32, width of the PC and instruction fields.
- `NOP`, 32'h0000_0000, instruction word driven on `ID_Instr` when the queue is empty.

- `CLK` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-high reset.
- `IF_Valid` in 1: fetch side presents a valid triple.
- `IF_PC` in XLEN: PC of the fetched instruction.
- `IF_PcPlus4` in XLEN: `nextPc` from the IF adder.
- `IF_Instr` in XLEN: fetched instruction word.
- `IF_Ready` out 1: queue can accept a push this cycle.
- `ID_Valid` out 1: head entry valid.
- `ID_PC` out XLEN: head PC.
- `ID_PcPlus4` out XLEN: head PC+4.
- `ID_Instr` out XLEN: head instruction.
- `ID_Ready` in 1: decoder consumes the head this cycle.
- `Flush` in 1: discard all entries (taken branch/jump resolved downstream).
- `Count` out $clog2(DEPTH+1): current occupancy.

## Operation
- Circular buffer with write pointer `wp`, read pointer `rp`, and occupancy `cnt`. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- push = `IF_Valid & IF_Ready`. On push, write the triple at `wp`, then `wp++`.
- pop = `ID_Valid & ID_Ready`. On pop, `rp++`.
- `cnt` next value: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- `IF_Ready = (cnt != DEPTH)`. This is a function of state only, with no combinational path from `ID_Ready`.
- `ID_Valid = (cnt != 0)`.
- `ID_*` fields come from the entry at `rp`. When the queue is empty they read `ID_PC`=0, `ID_PcPlus4`=0, `ID_Instr`=NOP.
- No bypass. An empty queue never forwards `IF_*` to `ID_*` in the same cycle.
- Full with pop: `IF_Ready`=0, so there is no push in that cycle. The freed slot is visible next cycle.
- Empty with push: `ID_Valid` rises after the edge.
- Push and pop together with 0<cnt<DEPTH: both take effect and `cnt` is unchanged.
- `Flush` has priority over push and pop. At the next edge `wp`, `rp`, and `cnt` go to 0 and any push or pop in that cycle is discarded. `IF_Ready` and `ID_Valid` keep their combinational definitions during the flush cycle.
- `IF_Valid` without `IF_Ready` is not an error. The fetch side holds the PC through the enable derived from `IF_Ready`.

## Timing
- Reset (asynchronous, any time, including mid-transfer) sets `wp`=`rp`=`cnt`=0. Resulting outputs: `IF_Ready`=1, `ID_Valid`=0, `ID_PC`=0, `ID_PcPlus4`=0, `ID_Instr`=NOP, `Count`=0. Storage contents are don't-care.
- Latency: a push at edge n appears on `ID_*` with `ID_Valid`=1 immediately after edge n, provided the queue was empty.
- Throughput: one push and one pop per cycle sustained.
- Flush asserted in cycle n: queue is empty after edge n. A push accepted in cycle n+1 is the first surviving entry.
- Storage is written only on push. Flush and reset do not clear the data array.

## Structure
- Shared pipeline package holds `XLEN`, the `NOP` encoding, and a packed `if_id_entry_t` = {pc, pc_plus4, instr}. The ID stage reuses this type.
- One sub-module: `if_id_fifo_mem`, a DEPTH×entry register array with one synchronous write port and one asynchronous read port.
- Pointer, count, and flush logic stay in the top module.

## Test plan
- Reset then `IF_Valid`=1 with PC=0x00, 0x04, 0x08 and `ID_Ready`=0 → `Count` goes 1 then 2. `IF_Ready` drops after the 2nd push. The 3rd triple is held off and `ID_PC` stays 0x00.
- Full queue, `ID_Ready`=1 for one cycle → `ID_PC` moves 0x00→0x04, `Count`=1, and `IF_Ready`=1 next cycle.
- Steady stream PC=0x00..0x3C step 4 with `ID_Ready`=1 → `ID_PC` follows one cycle behind, `Count` stays 1, and no word is lost or duplicated across the pointer wrap.
- Two entries queued, `Flush`=1 together with `IF_Valid`=1 (PC=0x50) → `Count`=0, `ID_Valid`=0, `ID_Instr`=NOP. The next push of PC=0x32 (branch target 50) becomes the head.
- `Reset` pulsed asynchronously between edges while `Count`=2 → outputs reach their reset values immediately without waiting for `CLK`. A push in the first cycle after release is accepted.
- Alternating `ID_Ready` 1/0 with continuous `IF_Valid` → the `ID_PC` sequence is strictly incrementing by 4 and `Count` never exceeds 2.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared pipeline package for the IF/ID boundary.
// Holds the datapath width, the NOP encoding shown to the decoder when
// nothing is queued, and the packed entry type that the ID stage reuses.
package if_id_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } if_id_entry_t;

    // Pointer width for a circular buffer of the given depth.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Handshake bundle between the fetch side, the queue and the decoder.
// Ports:
//   IF_Valid/IF_PC/IF_PcPlus4/IF_Instr : fetched triple, IF_Ready back-pressure
//   ID_Valid/ID_PC/ID_PcPlus4/ID_Instr : head entry, ID_Ready consume strobe
//   Flush : discard all entries, Count : occupancy
// Modports: master = pipeline environment (fetch + decode), slave = queue.
interface if_id_queue_if #(
    parameter int DEPTH = 2
);
    import if_id_queue_pkg::*;

    logic                         IF_Valid;
    logic [XLEN-1:0]              IF_PC;
    logic [XLEN-1:0]              IF_PcPlus4;
    logic [XLEN-1:0]              IF_Instr;
    logic                         IF_Ready;
    logic                         ID_Valid;
    logic [XLEN-1:0]              ID_PC;
    logic [XLEN-1:0]              ID_PcPlus4;
    logic [XLEN-1:0]              ID_Instr;
    logic                         ID_Ready;
    logic                         Flush;
    logic [$clog2(DEPTH+1)-1:0]   Count;

    modport master (
        output IF_Valid, IF_PC, IF_PcPlus4, IF_Instr, ID_Ready, Flush,
        input  IF_Ready, ID_Valid, ID_PC, ID_PcPlus4, ID_Instr, Count
    );

    modport slave (
        input  IF_Valid, IF_PC, IF_PcPlus4, IF_Instr, ID_Ready, Flush,
        output IF_Ready, ID_Valid, ID_PC, ID_PcPlus4, ID_Instr, Count
    );

endinterface

// File: rtl/if_id_fifo_mem.sv
// DEPTH x entry register array: one synchronous write port, one
// asynchronous read port. No reset; contents change only on write.
// Ports:
//   clk_i   : rising-edge clock
//   we_i    : write enable
//   waddr_i : write index, wdata_i : entry to store
//   raddr_i : read index,  rdata_o : entry at raddr_i (combinational)
module if_id_fifo_mem
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic         clk_i,
    input  logic         we_i,
    input  logic [PW-1:0] waddr_i,
    input  if_id_entry_t wdata_i,
    input  logic [PW-1:0] raddr_i,
    output if_id_entry_t rdata_o
);

    if_id_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read so a pushed entry is visible right after its edge.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Two-entry (DEPTH) instruction queue between IF and ID.
// Captures {PC, PC+4, instr} on a valid/ready handshake, presents the head
// to the decoder, and empties on Flush. IF_Ready depends on state only, so
// it can drive the PC enable without a path from ID_Ready.
// Ports:
//   CLK   : rising-edge clock
//   Reset : asynchronous active-high reset (pointers and count only)
//   bus   : slave side of if_id_queue_if (IF_*, ID_*, Flush, Count)
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int              DEPTH = 2,
    parameter logic [XLEN-1:0] NOP   = if_id_queue_pkg::NOP
) (
    input  logic          CLK,
    input  logic          Reset,
    if_id_queue_if.slave  bus
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic         if_ready;
    logic         id_valid;
    logic         push;
    logic         pop;
    if_id_entry_t wr_entry;
    if_id_entry_t rd_entry;

    assign if_ready = (cnt_q != CW'(DEPTH));
    assign id_valid = (cnt_q != '0);
    assign push     = bus.IF_Valid & if_ready;
    assign pop      = id_valid & bus.ID_Ready;

    assign wr_entry = '{pc: bus.IF_PC, pc_plus4: bus.IF_PcPlus4, instr: bus.IF_Instr};

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (bus.Flush) begin
            // Flush wins over any push/pop in the same cycle.
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wp_d = wp_q + PW'(1);
            if (pop)  rp_d = rp_q + PW'(1);
            if (push && !pop)      cnt_d = cnt_q + CW'(1);
            else if (pop && !push) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // A push discarded by Flush never reaches the array.
    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (push & ~bus.Flush),
        .waddr_i (wp_q),
        .wdata_i (wr_entry),
        .raddr_i (rp_q),
        .rdata_o (rd_entry)
    );

    // Empty queue shows a bubble, never stale array contents.
    assign bus.IF_Ready   = if_ready;
    assign bus.ID_Valid   = id_valid;
    assign bus.ID_PC      = id_valid ? rd_entry.pc       : '0;
    assign bus.ID_PcPlus4 = id_valid ? rd_entry.pc_plus4 : '0;
    assign bus.ID_Instr   = id_valid ? rd_entry.instr    : NOP;
    assign bus.Count      = cnt_q;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    logic CLK;
    logic Reset;
    int   n_checks;
    int   n_fail;

    if_id_queue_if #(.DEPTH(2)) bus ();

    if_id_queue #(.DEPTH(2)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc);
        bus.IF_Valid   = v;
        bus.IF_PC      = pc;
        bus.IF_PcPlus4 = pc + 32'd4;
        bus.IF_Instr   = instr_of(pc);
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Alternating-ready expectations, worked by hand.
    logic [31:0] alt_pc  [8] = '{32'h100, 32'h104, 32'h104, 32'h108,
                                 32'h108, 32'h10C, 32'h10C, 32'h110};
    logic [31:0] alt_cnt [8] = '{1, 1, 2, 1, 2, 1, 2, 1};

    initial begin
        logic [31:0] pc_fetch;
        logic        rdy_seen;
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        bus.Flush    = 1'b0;
        bus.ID_Ready = 1'b0;
        fetch(1'b0, 32'h0);
        #1;
        chk("rst_ifready", 32'(bus.IF_Ready), 32'd1);
        chk("rst_idvalid", 32'(bus.ID_Valid), 32'd0);
        chk("rst_idpc",    bus.ID_PC,         32'h0);
        chk("rst_idpc4",   bus.ID_PcPlus4,    32'h0);
        chk("rst_idinstr", bus.ID_Instr,      NOP);
        chk("rst_count",   32'(bus.Count),    32'd0);
        tick();
        tick();
        Reset = 1'b0;

        // Fill to full, third fetch held off.
        fetch(1'b1, 32'h00);
        tick();
        chk("fill1_count", 32'(bus.Count),    32'd1);
        chk("fill1_valid", 32'(bus.ID_Valid), 32'd1);
        chk("fill1_idpc",  bus.ID_PC,         32'h00);
        chk("fill1_instr", bus.ID_Instr,      32'hC0DE_0000);
        fetch(1'b1, 32'h04);
        tick();
        chk("fill2_count", 32'(bus.Count),    32'd2);
        chk("fill2_ready", 32'(bus.IF_Ready), 32'd0);
        fetch(1'b1, 32'h08);
        tick();
        chk("hold_count",  32'(bus.Count),    32'd2);
        chk("hold_idpc",   bus.ID_PC,         32'h00);

        // Full queue, one pop.
        bus.ID_Ready = 1'b1;
        tick();
        bus.ID_Ready = 1'b0;
        fetch(1'b0, 32'h0);
        chk("pop_idpc",    bus.ID_PC,         32'h04);
        chk("pop_idpc4",   bus.ID_PcPlus4,    32'h08);
        chk("pop_count",   32'(bus.Count),    32'd1);
        chk("pop_ready",   32'(bus.IF_Ready), 32'd1);

        // Empty then stream 0x00..0x3C across pointer wraps.
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        chk("empty_count", 32'(bus.Count),    32'd0);
        bus.ID_Ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            fetch(1'b1, 32'(4 * k));
            tick();
            chk("strm_idpc",  bus.ID_PC,      32'(4 * k));
            chk("strm_instr", bus.ID_Instr,   instr_of(32'(4 * k)));
            chk("strm_count", 32'(bus.Count), 32'd1);
        end
        fetch(1'b0, 32'h0);
        tick();
        bus.ID_Ready = 1'b0;
        chk("drain_count", 32'(bus.Count),    32'd0);

        // Flush with a simultaneous push.
        fetch(1'b1, 32'h40);
        tick();
        fetch(1'b1, 32'h44);
        tick();
        fetch(1'b1, 32'h50);
        bus.Flush = 1'b1;
        #1;
        chk("fl_pre_ready", 32'(bus.IF_Ready), 32'd0);
        chk("fl_pre_valid", 32'(bus.ID_Valid), 32'd1);
        tick();
        bus.Flush = 1'b0;
        chk("fl_count",    32'(bus.Count),    32'd0);
        chk("fl_valid",    32'(bus.ID_Valid), 32'd0);
        chk("fl_instr",    bus.ID_Instr,      NOP);
        chk("fl_idpc",     bus.ID_PC,         32'h0);
        fetch(1'b1, 32'h32);
        tick();
        chk("tgt_idpc",    bus.ID_PC,         32'h32);
        chk("tgt_count",   32'(bus.Count),    32'd1);

        // Asynchronous reset between edges with two entries queued.
        fetch(1'b1, 32'h60);
        tick();
        fetch(1'b0, 32'h0);
        chk("ar_pre_count", 32'(bus.Count),   32'd2);
        #2;
        Reset = 1'b1;
        #1;
        chk("ar_count",    32'(bus.Count),    32'd0);
        chk("ar_valid",    32'(bus.ID_Valid), 32'd0);
        chk("ar_ready",    32'(bus.IF_Ready), 32'd1);
        chk("ar_idpc",     bus.ID_PC,         32'h0);
        chk("ar_instr",    bus.ID_Instr,      NOP);
        #1;
        Reset = 1'b0;
        fetch(1'b1, 32'h70);
        tick();
        chk("ar_push_pc",  bus.ID_PC,         32'h70);
        chk("ar_push_cnt", 32'(bus.Count),    32'd1);

        // Alternating ID_Ready with continuous fetch; PC advances only when accepted.
        fetch(1'b0, 32'h0);
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        pc_fetch = 32'h100;
        for (int i = 0; i < 8; i++) begin
            fetch(1'b1, pc_fetch);
            bus.ID_Ready = (i % 2) == 1;
            rdy_seen = bus.IF_Ready;
            tick();
            if (rdy_seen) pc_fetch = pc_fetch + 32'd4;
            chk("alt_idpc",  bus.ID_PC,      alt_pc[i]);
            chk("alt_count", 32'(bus.Count), alt_cnt[i]);
        end
        fetch(1'b0, 32'h0);
        bus.ID_Ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
